// File: rtl/reg_stream_fifo_pkg.sv
// Shared definitions for the register stream FIFO and the downstream
// reset-to-constant data register stage.
//   STREAM_WIDTH  data width of the stream
//   STREAM_INIT   value the downstream register resets to; the FIFO shows
//                 it on O_data whenever it is empty
//   clog2_count   bits needed to hold an occupancy of 0..depth
package reg_stream_fifo_pkg;

    localparam int                    STREAM_WIDTH = 8;
    localparam logic [STREAM_WIDTH-1:0] STREAM_INIT  = 8'hDE;

    function automatic int clog2_count(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/reg_stream_fifo_mem.sv
// Storage array for reg_stream_fifo: DEPTH x WIDTH registers, one synchronous
// write port and one asynchronous read port. The array has no reset, so its
// contents are undefined until written.
// Ports:
//   clk    clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  read data (combinational from raddr)
module reg_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/reg_stream_fifo.sv
// First-word-fall-through valid/ready FIFO feeding the reset-to-constant data
// register stage. The head word is visible on O_data while O_valid is high;
// when empty, O_data shows INIT, the same constant the downstream register
// resets to.
// Ports:
//   CLK      clock, all state updates on the rising edge
//   RESET    synchronous active-high reset
//   I_data   write data
//   I_valid  producer offers I_data
//   I_ready  FIFO can accept (not full)
//   O_data   head entry, or INIT when empty
//   O_valid  head entry valid (not empty)
//   O_ready  consumer takes the head this cycle
//   count    current occupancy, 0..DEPTH
module reg_stream_fifo
    import reg_stream_fifo_pkg::*;
#(
    parameter int               WIDTH = STREAM_WIDTH,
    parameter int               DEPTH = 4,
    parameter logic [WIDTH-1:0] INIT  = STREAM_INIT
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [WIDTH-1:0]              I_data,
    input  logic                          I_valid,
    output logic                          I_ready,
    output logic [WIDTH-1:0]              O_data,
    output logic                          O_valid,
    input  logic                          O_ready,
    output logic [clog2_count(DEPTH)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = clog2_count(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push, pop;
    logic [WIDTH-1:0] rdata;

    // Ready/valid depend only on the registered count, so there is no
    // combinational path from I_valid/O_ready back to them.
    assign I_ready = (count_q != FULL_CNT);
    assign O_valid = (count_q != '0);
    assign push    = I_valid & I_ready;
    assign pop     = O_valid & O_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Writes are suppressed during reset so a reset cycle performs no push.
    reg_fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (CLK),
        .we    (push & ~RESET),
        .waddr (wr_ptr_q),
        .wdata (I_data),
        .raddr (rd_ptr_q),
        .rdata (rdata)
    );

    assign O_data = (count_q == '0) ? INIT : rdata;
    assign count  = count_q;

endmodule

// File: tb/tb_reg_stream_fifo.sv
module tb_reg_stream_fifo;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] I_data;
    logic       I_valid;
    logic       I_ready;
    logic [7:0] O_data;
    logic       O_valid;
    logic       O_ready;
    logic [2:0] count;

    int n_checks = 0;
    int n_fail   = 0;

    reg_stream_fifo dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .I_data  (I_data),
        .I_valid (I_valid),
        .I_ready (I_ready),
        .O_data  (O_data),
        .O_valid (O_valid),
        .O_ready (O_ready),
        .count   (count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are stable 1 time unit after the edge.
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_word(input logic [7:0] d);
        I_data  = d;
        I_valid = 1'b1;
        step();
        I_valid = 1'b0;
    endtask

    logic [7:0] fill_vec [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] full_vec [4] = '{8'hA2, 8'hA3, 8'hA4, 8'hAA};

    initial begin
        RESET   = 1'b1;
        I_data  = 8'h77;
        I_valid = 1'b1;
        O_ready = 1'b0;

        // 1 reset with I_valid held high
        step();
        step();
        check("rst_count",   count,   0);
        check("rst_ovalid",  O_valid, 0);
        check("rst_iready",  I_ready, 1);
        check("rst_odata",   O_data,  8'hDE);
        RESET   = 1'b0;
        I_valid = 1'b0;
        step();
        check("rst_nothing_stored", count, 0);

        // 2 fill, reject while full, drain
        for (int i = 0; i < 4; i++) push_word(fill_vec[i]);
        check("fill_count",  count,   4);
        check("fill_iready", I_ready, 0);
        check("fill_odata",  O_data,  8'h11);
        push_word(8'h55);
        check("full_reject_count", count,  4);
        check("full_reject_odata", O_data, 8'h11);
        O_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_%0d", i), O_data, fill_vec[i]);
            step();
            check($sformatf("drain_cnt_%0d", i), count, 3 - i);
        end
        check("drain_odata_init", O_data,  8'hDE);
        check("drain_ovalid",     O_valid, 0);

        // 3 streaming with continuous push and pop, pointers wrap
        I_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            I_data = 8'h60 + 8'(i);
            if (i > 0) check($sformatf("wrap_data_%0d", i - 1), O_data, 8'h60 + 8'(i - 1));
            step();
            check($sformatf("wrap_cnt_%0d", i), count, 1);
        end
        I_valid = 1'b0;
        check("wrap_data_9", O_data, 8'h69);
        step();
        check("wrap_empty", count, 0);

        // 4 full with simultaneous pop: offered word rejected, accepted next cycle
        O_ready = 1'b0;
        push_word(8'hA1);
        push_word(8'hA2);
        push_word(8'hA3);
        push_word(8'hA4);
        check("fp_full", count, 4);
        I_data  = 8'hAA;
        I_valid = 1'b1;
        O_ready = 1'b1;
        step();
        check("fp_count",  count,   3);
        check("fp_iready", I_ready, 1);
        check("fp_head",   O_data,  8'hA2);
        O_ready = 1'b0;
        step();
        I_valid = 1'b0;
        check("fp_accept_count", count, 4);
        O_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("fp_drain_%0d", i), O_data, full_vec[i]);
            step();
        end
        check("fp_empty", count, 0);

        // 5 reset mid-operation with push and pop offered
        O_ready = 1'b0;
        push_word(8'hB1);
        push_word(8'hB2);
        push_word(8'hB3);
        check("mr_pre_count", count, 3);
        RESET   = 1'b1;
        I_data  = 8'h5A;
        I_valid = 1'b1;
        O_ready = 1'b1;
        step();
        check("mr_count",  count,   0);
        check("mr_ovalid", O_valid, 0);
        check("mr_odata",  O_data,  8'hDE);
        RESET   = 1'b0;
        O_ready = 1'b0;
        step();
        I_valid = 1'b0;
        check("mr_post_count", count,   1);
        check("mr_post_data",  O_data,  8'h5A);
        check("mr_post_valid", O_valid, 1);
        O_ready = 1'b1;
        step();
        check("mr_drain", count, 0);

        // 6 pop attempts while empty
        for (int i = 0; i < 3; i++) begin
            step();
            check($sformatf("ep_count_%0d", i),  count,   0);
            check($sformatf("ep_ovalid_%0d", i), O_valid, 0);
            check($sformatf("ep_odata_%0d", i),  O_data,  8'hDE);
        end
        O_ready = 1'b0;
        push_word(8'hC3);
        push_word(8'hC4);
        check("ep_after_head", O_data, 8'hC3);
        O_ready = 1'b1;
        step();
        check("ep_after_next", O_data, 8'hC4);
        step();
        check("ep_after_empty", count, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
